// File: rtl/demux_bus_arbiter_pkg.sv
// Shared constants and types for the credit-based demux bus arbiter.
package demux_bus_arbiter_pkg;

  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_NUM_REQ      = 4;
  localparam int DEF_BUS_WIDTH    = 8;
  localparam int DEF_CREDITS      = 4;
  localparam int DEF_CREDIT_WIDTH = $clog2(DEF_CREDITS + 1);

  // Credit counter at the default lane buffer depth.
  typedef logic [DEF_CREDIT_WIDTH-1:0] credit_t;

  typedef enum logic {
    PAUSE = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Sticky error flag positions in err_out.
  localparam int ERR_BAD_DEST   = 0;
  localparam int ERR_CREDIT_OVF = 1;

endpackage

// File: rtl/demux_bus_arbiter_ctrl_if.sv
// Requester / demux-stage bus bundle for the arbiter.
interface demux_bus_arbiter_ctrl_if
  import demux_bus_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int BUS_WIDTH  = DEF_BUS_WIDTH,
  parameter int SEL_WIDTH  = $clog2(BUS_WIDTH),
  parameter int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);

  logic [NUM_REQ-1:0]    req_valid;
  logic [DATA_WIDTH-1:0] req_data [NUM_REQ];
  logic [SEL_WIDTH-1:0]  req_dest [NUM_REQ];
  logic [NUM_REQ-1:0]    req_ready;
  logic [BUS_WIDTH-1:0]  credit_return;
  logic [SEL_WIDTH-1:0]  sel_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic [BUS_WIDTH-1:0]  data_out_valid;
  logic [ID_WIDTH-1:0]   grant_id_out;

  // Requesters and consumers drive requests and credit returns.
  modport master (
    output req_valid, req_data, req_dest, credit_return,
    input  req_ready, sel_out, data_out, data_out_valid, grant_id_out
  );

  // The arbiter accepts requests and drives the demux stage.
  modport slave (
    input  req_valid, req_data, req_dest, credit_return,
    output req_ready, sel_out, data_out, data_out_valid, grant_id_out
  );

endinterface

// File: rtl/demux_bus_arbiter_ctrl_rr_grant_picker.sv
// Combinational round-robin picker: first eligible requester at or after rr_ptr.
module rr_grant_picker
  import demux_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int IDX_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0]   eligible,
  input  logic [IDX_WIDTH-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]   grant,
  output logic [IDX_WIDTH-1:0] grant_idx,
  output logic                 grant_any
);

  // Scan from the farthest offset back towards rr_ptr so the nearest eligible one wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (eligible[(int'(rr_ptr) + k) % NUM_REQ]) begin
        grant_idx = IDX_WIDTH'((int'(rr_ptr) + k) % NUM_REQ);
        grant_any = 1'b1;
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/demux_bus_arbiter_ctrl.sv
// Credit-based round-robin arbiter sharing one demux bus among NUM_REQ requesters.
//
// state | meaning
// PAUSE | no grants; idle_out reported once all lane credits are home
// RUN   | arbitrate each cycle among requesters whose lane holds a credit
module demux_bus_arbiter_ctrl
  import demux_bus_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int BUS_WIDTH    = DEF_BUS_WIDTH,
  parameter int SEL_WIDTH    = $clog2(BUS_WIDTH),
  parameter int CREDITS      = DEF_CREDITS,
  parameter int CREDIT_WIDTH = $clog2(CREDITS + 1),
  parameter int ID_WIDTH     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      ap_clk,
  input  logic                      areset,
  input  logic                      enable_in,
  demux_bus_arbiter_ctrl_if.slave   bus,
  output logic                      idle_out,
  output logic [1:0]                err_out
);

  state_t                  state;
  logic [ID_WIDTH-1:0]     rr_ptr;
  logic [CREDIT_WIDTH-1:0] credit [BUS_WIDTH];

  logic                    running;
  logic [NUM_REQ-1:0]      eligible;
  logic [NUM_REQ-1:0]      grant;
  logic [ID_WIDTH-1:0]     win;
  logic                    win_any;
  logic [SEL_WIDTH-1:0]    win_dest;
  logic [DATA_WIDTH-1:0]   win_data;
  logic                    win_dest_ok;
  logic [BUS_WIDTH-1:0]    lane_take;
  logic [BUS_WIDTH-1:0]    lane_ovf;
  logic                    all_full;

  // No handshakes while reset is held, so nothing is accepted and then lost.
  assign running = (state == RUN) && !areset;

  // A requester is eligible if its lane has a credit, or its lane does not exist (granted and dropped).
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (running && bus.req_valid[i]) begin
        if (int'(bus.req_dest[i]) >= BUS_WIDTH) begin
          eligible[i] = 1'b1;
        end else begin
          for (int d = 0; d < BUS_WIDTH; d++) begin
            if (bus.req_dest[i] == SEL_WIDTH'(d) && credit[d] != '0) eligible[i] = 1'b1;
          end
        end
      end
    end
  end

  rr_grant_picker #(
    .NUM_REQ   (NUM_REQ),
    .IDX_WIDTH (ID_WIDTH)
  ) u_picker (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (win),
    .grant_any (win_any)
  );

  assign bus.req_ready = grant;
  assign win_dest      = bus.req_dest[win];
  assign win_data      = bus.req_data[win];
  assign win_dest_ok   = int'(win_dest) < BUS_WIDTH;

  // Per-lane grant decode, overflow detect and the all-credits-home flag.
  always_comb begin
    lane_take = '0;
    lane_ovf  = '0;
    all_full  = 1'b1;
    for (int d = 0; d < BUS_WIDTH; d++) begin
      lane_take[d] = win_any && win_dest_ok && (win_dest == SEL_WIDTH'(d));
      lane_ovf[d]  = bus.credit_return[d] && !lane_take[d] &&
                     (credit[d] == CREDIT_WIDTH'(CREDITS));
      if (credit[d] != CREDIT_WIDTH'(CREDITS)) all_full = 1'b0;
    end
  end

  assign idle_out = (state == PAUSE) && all_full;

  // Lane credits: grant takes one, return gives one back, both together cancel; saturate on overflow.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      for (int d = 0; d < BUS_WIDTH; d++) credit[d] <= CREDIT_WIDTH'(CREDITS);
    end else begin
      for (int d = 0; d < BUS_WIDTH; d++) begin
        if (lane_take[d] && !bus.credit_return[d]) begin
          credit[d] <= credit[d] - CREDIT_WIDTH'(1);
        end else if (bus.credit_return[d] && !lane_take[d] && !lane_ovf[d]) begin
          credit[d] <= credit[d] + CREDIT_WIDTH'(1);
        end
      end
    end
  end

  // FSM, round-robin pointer, registered demux outputs and sticky errors.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state              <= PAUSE;
      rr_ptr             <= '0;
      bus.sel_out        <= '0;
      bus.data_out       <= '0;
      bus.data_out_valid <= '0;
      bus.grant_id_out   <= '0;
      err_out            <= '0;
    end else begin
      case (state)
        PAUSE:   if (enable_in)  state <= RUN;
        RUN:     if (!enable_in) state <= PAUSE;
        default: state <= PAUSE;
      endcase

      bus.data_out_valid <= '0;
      if (win_any) begin
        rr_ptr           <= (win == ID_WIDTH'(NUM_REQ - 1)) ? '0 : win + ID_WIDTH'(1);
        bus.sel_out      <= win_dest;
        bus.data_out     <= win_data;
        bus.grant_id_out <= win;
        if (win_dest_ok) bus.data_out_valid <= BUS_WIDTH'(1) << win_dest;
        else             err_out[ERR_BAD_DEST] <= 1'b1;
      end

      if (|lane_ovf) err_out[ERR_CREDIT_OVF] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_demux_bus_arbiter_ctrl.sv
// Self-checking bench for demux_bus_arbiter_ctrl: vector table, directed sequences, random vs model.
module tb_demux_bus_arbiter_ctrl;
  import demux_bus_arbiter_pkg::*;

  localparam int NR = 4;
  localparam int BW = 8;
  localparam int DW = 32;
  localparam int CR = 4;

  logic       ap_clk = 1'b0;
  logic       areset = 1'b1;
  logic       enable_in = 1'b0;
  logic       enable6 = 1'b0;
  logic       idle_out, idle6;
  logic [1:0] err_out, err6;

  int n_tests = 0;
  int n_fail  = 0;

  demux_bus_arbiter_ctrl_if #(.DATA_WIDTH(DW), .NUM_REQ(NR), .BUS_WIDTH(BW)) bus ();
  demux_bus_arbiter_ctrl_if #(.DATA_WIDTH(DW), .NUM_REQ(NR), .BUS_WIDTH(6))  bus6 ();

  demux_bus_arbiter_ctrl #(.DATA_WIDTH(DW), .NUM_REQ(NR), .BUS_WIDTH(BW), .CREDITS(CR)) u_dut (
    .ap_clk(ap_clk), .areset(areset), .enable_in(enable_in), .bus(bus),
    .idle_out(idle_out), .err_out(err_out)
  );

  demux_bus_arbiter_ctrl #(.DATA_WIDTH(DW), .NUM_REQ(NR), .BUS_WIDTH(6), .CREDITS(CR)) u_dut6 (
    .ap_clk(ap_clk), .areset(areset), .enable_in(enable6), .bus(bus6),
    .idle_out(idle6), .err_out(err6)
  );

  always #5 ap_clk = ~ap_clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int              m_credit [BW];
  int              m_rr;
  bit              m_run;
  bit [1:0]        m_err;
  int              m_sel, m_gid;
  logic [DW-1:0]   m_data;
  logic [BW-1:0]   m_valid;

  function automatic void m_reset();
    for (int l = 0; l < BW; l++) m_credit[l] = CR;
    m_rr = 0; m_run = 0; m_err = 0; m_sel = 0; m_gid = 0; m_data = '0; m_valid = '0;
  endfunction

  function automatic bit m_all_full();
    for (int l = 0; l < BW; l++) if (m_credit[l] != CR) return 0;
    return 1;
  endfunction

  function automatic int model_pick();
    int i;
    if (areset || !m_run) return -1;
    for (int k = 0; k < NR; k++) begin
      i = (m_rr + k) % NR;
      if (bus.req_valid[i] && m_credit[int'(bus.req_dest[i])] > 0) return i;
    end
    return -1;
  endfunction

  function automatic void model_update(input int w);
    int  d;
    bit  take, give;
    if (areset) begin
      m_reset();
      return;
    end
    d = -1;
    m_valid = '0;
    if (w >= 0) begin
      d       = int'(bus.req_dest[w]);
      m_sel   = d;
      m_data  = bus.req_data[w];
      m_gid   = w;
      m_valid = BW'(1) << d;
      m_rr    = (w + 1) % NR;
    end
    for (int l = 0; l < BW; l++) begin
      take = (d == l);
      give = bus.credit_return[l];
      if (take && !give) m_credit[l]--;
      else if (give && !take) begin
        if (m_credit[l] == CR) m_err[1] = 1'b1;
        else m_credit[l]++;
      end
    end
    m_run = enable_in;
  endfunction

  // One clock of the main DUT: inputs were set after the previous falling edge.
  task automatic cycle(input string tag, output logic [NR-1:0] rdy);
    int w;
    logic [NR-1:0] er;
    #1;
    w  = model_pick();
    er = (w >= 0) ? (NR'(1) << w) : '0;
    rdy = bus.req_ready;
    check({tag, "/ready"}, bus.req_ready, er);
    @(posedge ap_clk);
    model_update(w);
    #1;
    check({tag, "/valid"}, bus.data_out_valid, m_valid);
    check({tag, "/sel"}, bus.sel_out, m_sel);
    check({tag, "/data"}, bus.data_out, m_data);
    check({tag, "/gid"}, bus.grant_id_out, m_gid);
    check({tag, "/idle"}, idle_out, (!m_run && m_all_full()));
    check({tag, "/err"}, err_out, m_err);
    @(negedge ap_clk);
  endtask

  task automatic clr_inputs();
    bus.req_valid = '0;
    bus.credit_return = '0;
    for (int i = 0; i < NR; i++) begin
      bus.req_data[i] = '0;
      bus.req_dest[i] = '0;
    end
  endtask

  task automatic clr6();
    bus6.req_valid = '0;
    bus6.credit_return = '0;
    for (int i = 0; i < NR; i++) begin
      bus6.req_data[i] = '0;
      bus6.req_dest[i] = '0;
    end
  endtask

  task automatic set_req(input int i, input logic v, input int dest, input logic [DW-1:0] data);
    bus.req_valid[i] = v;
    bus.req_dest[i]  = 3'(dest);
    bus.req_data[i]  = data;
  endtask

  task automatic do_reset();
    logic [NR-1:0] r;
    clr_inputs();
    enable_in = 1'b0;
    areset = 1'b1;
    cycle("reset", r);
    areset = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic          en;
    logic [NR-1:0] vld;
    logic [11:0]   dest;      // {req3, req2, req1, req0}, 3 bits each
    logic [NR-1:0] exp_ready;
    logic [BW-1:0] exp_valid;
    logic [1:0]    exp_gid;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [NR-1:0] r;
    int cnt;

    vecs[0] = '{en: 1'b1, vld: 4'b0101, dest: {3'd0, 3'd5, 3'd0, 3'd3}, exp_ready: 4'b0000, exp_valid: 8'h00, exp_gid: 2'd0};
    vecs[1] = '{en: 1'b1, vld: 4'b0101, dest: {3'd0, 3'd5, 3'd0, 3'd3}, exp_ready: 4'b0001, exp_valid: 8'h08, exp_gid: 2'd0};
    vecs[2] = '{en: 1'b1, vld: 4'b0100, dest: {3'd0, 3'd5, 3'd0, 3'd3}, exp_ready: 4'b0100, exp_valid: 8'h20, exp_gid: 2'd2};
    vecs[3] = '{en: 1'b1, vld: 4'b1001, dest: {3'd0, 3'd5, 3'd0, 3'd3}, exp_ready: 4'b1000, exp_valid: 8'h01, exp_gid: 2'd3};
    vecs[4] = '{en: 1'b1, vld: 4'b0000, dest: {3'd0, 3'd5, 3'd0, 3'd3}, exp_ready: 4'b0000, exp_valid: 8'h00, exp_gid: 2'd3};

    clr_inputs();
    clr6();
    m_reset();
    areset = 1'b1;
    repeat (2) @(negedge ap_clk);

    // reset state
    check("rst/valid", bus.data_out_valid, 0);
    check("rst/sel", bus.sel_out, 0);
    check("rst/data", bus.data_out, 0);
    check("rst/gid", bus.grant_id_out, 0);
    check("rst/err", err_out, 0);
    check("rst/idle", idle_out, 1);
    check("rst/ready", bus.req_ready, 0);
    check("rst6/idle", idle6, 1);
    check("rst6/err", err6, 0);
    areset = 1'b0;

    // table: requesters 0 and 2 to lanes 3 and 5, then 3 wins from rr_ptr=3
    for (int v = 0; v < 5; v++) begin
      enable_in = vecs[v].en;
      bus.req_valid = vecs[v].vld;
      for (int i = 0; i < NR; i++) begin
        bus.req_dest[i] = vecs[v].dest[i*3 +: 3];
        bus.req_data[i] = 32'hD000_0000 + 32'(i);
      end
      #1;
      check($sformatf("vec%0d/ready", v), bus.req_ready, vecs[v].exp_ready);
      @(posedge ap_clk);
      #1;
      check($sformatf("vec%0d/valid", v), bus.data_out_valid, vecs[v].exp_valid);
      check($sformatf("vec%0d/gid", v), bus.grant_id_out, vecs[v].exp_gid);
      @(negedge ap_clk);
    end

    // credit exhaustion on lane 1, then one return buys one grant
    do_reset();
    enable_in = 1'b1;
    cycle("A/warm", r);
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      set_req(0, 1'b1, 1, 32'h100 + 32'(c));
      cycle("A/stream", r);
      cnt += int'(r[0]);
    end
    check("A/grants_no_return", cnt, 4);
    bus.credit_return[1] = 1'b1;
    cycle("A/ret", r);
    cnt = int'(r[0]);
    bus.credit_return[1] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cycle("A/after", r);
      cnt += int'(r[0]);
    end
    check("A/grants_after_return", cnt, 1);

    // all four requesters to distinct lanes, delivered words returned next cycle
    do_reset();
    enable_in = 1'b1;
    cycle("C/warm", r);
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, i, 32'hC0 + 32'(i));
    for (int c = 0; c < 16; c++) begin
      bus.credit_return = bus.data_out_valid;
      cycle("C/rr", r);
      check($sformatf("C/order%0d", c), r, NR'(1) << (c % NR));
    end

    // grant and return on lane 2 at credit 2 cancel out
    do_reset();
    enable_in = 1'b1;
    cycle("D/warm", r);
    set_req(0, 1'b1, 2, 32'hD2);
    cycle("D/g1", r);
    cycle("D/g2", r);
    bus.credit_return[2] = 1'b1;
    cycle("D/same", r);
    check("D/same_grant", r, 4'b0001);
    bus.credit_return[2] = 1'b0;
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      cycle("D/rest", r);
      cnt += int'(r[0]);
    end
    check("D/remaining_grants", cnt, 2);

    // return at full credit saturates and flags overflow
    do_reset();
    enable_in = 1'b1;
    bus.credit_return[5] = 1'b1;
    cycle("D/ovf", r);
    bus.credit_return = '0;
    check("D/err_ovf", err_out[ERR_CREDIT_OVF], 1);
    set_req(0, 1'b1, 5, 32'hD5);
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      cycle("D/full", r);
      cnt += int'(r[0]);
    end
    check("D/grants_after_ovf", cnt, 4);

    // bad destination on the 6-lane instance
    do_reset();
    enable6 = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    bus6.req_valid = 4'b0001;
    bus6.req_dest[0] = 3'd7;
    bus6.req_data[0] = 32'hBAD0;
    #1;
    check("E/ready", bus6.req_ready, 4'b0001);
    @(posedge ap_clk);
    #1;
    check("E/valid", bus6.data_out_valid, 0);
    check("E/err_bad", err6[ERR_BAD_DEST], 1);
    check("E/err_ovf", err6[ERR_CREDIT_OVF], 0);
    @(negedge ap_clk);
    bus6.req_valid = '0;
    enable6 = 1'b0;
    @(posedge ap_clk);
    @(negedge ap_clk);
    check("E/idle_credits_full", idle6, 1);
    enable6 = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    bus6.req_valid = 4'b0011;
    bus6.req_dest[0] = 3'd0;
    bus6.req_dest[1] = 3'd1;
    #1;
    check("E/rr_advanced", bus6.req_ready, 4'b0010);
    @(posedge ap_clk);
    #1;
    check("E/valid_lane1", bus6.data_out_valid, 6'h02);
    @(negedge ap_clk);
    clr6();
    enable6 = 1'b0;

    // enable falls mid-stream: the grant in that cycle still lands, then silence
    do_reset();
    enable_in = 1'b1;
    cycle("F/warm", r);
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 4 + i, 32'hF0 + 32'(i));
    for (int c = 0; c < 3; c++) cycle("F/run", r);
    enable_in = 1'b0;
    cycle("F/fall", r);
    cnt = (bus.data_out_valid != '0) ? 1 : 0;
    for (int c = 0; c < 3; c++) begin
      cycle("F/paused", r);
      cnt += (bus.data_out_valid != '0) ? 1 : 0;
    end
    check("F/words_after_fall", cnt, 1);
    bus.req_valid = '0;
    for (int c = 0; c < 8 && !m_all_full(); c++) begin
      for (int l = 0; l < BW; l++) bus.credit_return[l] = (m_credit[l] < CR);
      cycle("F/drain", r);
    end
    bus.credit_return = '0;
    check("F/idle", idle_out, 1);

    // reset in the middle of traffic
    enable_in = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, i, 32'hAA + 32'(i));
    for (int c = 0; c < 3; c++) cycle("F/traffic", r);
    areset = 1'b1;
    cycle("F/rst", r);
    areset = 1'b0;
    check("F/rst_valid", bus.data_out_valid, 0);
    check("F/rst_sel", bus.sel_out, 0);
    check("F/rst_data", bus.data_out, 0);
    check("F/rst_gid", bus.grant_id_out, 0);
    check("F/rst_err", err_out, 0);
    check("F/rst_idle", idle_out, 1);

    // random traffic against the model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      enable_in = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < NR; i++)
        set_req(i, ($urandom_range(0, 2) != 0), int'($urandom_range(0, BW - 1)), $urandom);
      for (int l = 0; l < BW; l++)
        bus.credit_return[l] = (m_credit[l] < CR) ? ($urandom_range(0, 2) == 0)
                                                  : ($urandom_range(0, 31) == 0);
      cycle("R", r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
